// File: rtl/ahb_payload_serializer_if.sv
// ahb_payload_serializer_if: programmed payload/control inputs and serial/status outputs of the serializer
interface ahb_payload_serializer_if #(parameter int DATA_W = 8, parameter int SIZE_W = 5);
  logic [DATA_W-1:0] payload_0, payload_1;
  logic [SIZE_W-1:0] data_size;
  logic start, serial_out, serial_valid, parity_bit, busy, done, err;
  modport master(output payload_0, payload_1, data_size, start,
                 input serial_out, serial_valid, parity_bit, busy, done, err);
  modport slave(input payload_0, payload_1, data_size, start,
                output serial_out, serial_valid, parity_bit, busy, done, err);
endinterface

// File: rtl/ahb_payload_serializer.sv
// ahb_payload_serializer: LSB-first serializer of {payload_1,payload_0}, CLK_DIV cycles per bit.
// Optional even parity period is enabled by defining AHB_SER_PARITY_EN.
module ahb_payload_serializer #(
  parameter int DATA_W  = 8,
  parameter int SIZE_W  = 5,
  parameter int CLK_DIV = 4
) (
  input logic hclk,
  input logic hreset_n,
  ahb_payload_serializer_if.slave s
);
  localparam int DIV_W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
`ifdef AHB_SER_PARITY_EN
    PARITY = 2'd3,
`endif
    DONE   = 2'd2
  } state_t;
  state_t state_q, state_d, after_shift;
  logic [2*DATA_W-1:0] shreg_q, shreg_d;
  logic [SIZE_W-1:0] bits_q, bits_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic err_q, err_d, wrap, legal, par_q, par_d;
  assign wrap  = div_q == DIV_W'(CLK_DIV - 1);
  assign legal = s.data_size != '0 && s.data_size <= SIZE_W'(2 * DATA_W);
`ifdef AHB_SER_PARITY_EN
  assign after_shift = PARITY;
`else
  assign after_shift = DONE;
`endif
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bits_d  = bits_q;
    div_d   = wrap ? '0 : div_q + DIV_W'(1);
    err_d   = 1'b0;
    par_d   = par_q;
    case (state_q)
      IDLE: begin
        div_d = '0;
        if (s.start && legal) begin
          shreg_d = {s.payload_1, s.payload_0};
          bits_d  = s.data_size;
          par_d   = 1'b0;
          state_d = SHIFT;
        end
        err_d = s.start && !legal;
      end
      SHIFT: if (wrap) begin
        shreg_d = shreg_q >> 1;
        bits_d  = bits_q - SIZE_W'(1);
        par_d   = par_q ^ shreg_q[0];
        state_d = bits_q == SIZE_W'(1) ? after_shift : SHIFT;
      end
`ifdef AHB_SER_PARITY_EN
      PARITY: state_d = wrap ? DONE : PARITY;
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge hclk or negedge hreset_n)
    if (!hreset_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      bits_q  <= '0;
      div_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bits_q  <= bits_d;
      div_q   <= div_d;
      err_q   <= err_d;
    end
`ifdef AHB_SER_PARITY_EN
  always_ff @(posedge hclk or negedge hreset_n)
    if (!hreset_n) par_q <= 1'b0;
    else par_q <= par_d;
  assign s.parity_bit   = state_q == PARITY;
  assign s.serial_valid = state_q == SHIFT || state_q == PARITY;
  assign s.serial_out   = state_q == SHIFT ? shreg_q[0] : state_q == PARITY && par_q;
`else
  assign par_q          = 1'b0;
  assign s.parity_bit   = 1'b0;
  assign s.serial_valid = state_q == SHIFT;
  assign s.serial_out   = state_q == SHIFT && shreg_q[0];
`endif
  assign s.busy = s.serial_valid;
  assign s.done = state_q == DONE;
  assign s.err  = err_q;
  logic unused;
  assign unused = ^{par_d};
endmodule

// File: tb/tb_ahb_payload_serializer.sv
// tb_ahb_payload_serializer: directed and random frames checked against a bit-queue model of the frame.
module tb_ahb_payload_serializer;
  localparam int DATA_W = 8, SIZE_W = 5, CLK_DIV = 4;
  logic hclk = 1'b0, hreset_n = 1'b0;
  int checks = 0, errors = 0;
  ahb_payload_serializer_if #(.DATA_W(DATA_W), .SIZE_W(SIZE_W)) bus();
  ahb_payload_serializer #(.DATA_W(DATA_W), .SIZE_W(SIZE_W), .CLK_DIV(CLK_DIV)) dut (
    .hclk(hclk), .hreset_n(hreset_n), .s(bus.slave));
  always #5 hclk = ~hclk;
  task automatic tick();
    @(posedge hclk);
    #1;
  endtask
  function automatic logic [5:0] outs();
    return {bus.serial_out, bus.serial_valid, bus.parity_bit, bus.busy, bus.done, bus.err};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Expected per-cycle {serial_out, parity_bit} derived from the frame contents.
  task automatic run_frame(input logic [7:0] p0, input logic [7:0] p1, input int size, input int poke);
    logic [15:0] frame;
    logic [1:0] q[$];
    logic par;
    frame = {p1, p0};
    par = 1'b0;
    for (int i = 0; i < size; i++) begin
      par ^= frame[i];
      repeat (CLK_DIV) q.push_back({frame[i], 1'b0});
    end
`ifdef AHB_SER_PARITY_EN
    repeat (CLK_DIV) q.push_back({par, 1'b1});
`endif
    bus.payload_0 = p0;
    bus.payload_1 = p1;
    bus.data_size = SIZE_W'(size);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 0; c < q.size(); c++) begin
      chk("frame_bit", {26'd0, outs()}, {26'd0, q[c][1], 1'b1, q[c][0], 1'b1, 1'b0, 1'b0});
      bus.start = c == poke;
      if (c == poke) bus.payload_0 = ~bus.payload_0;
      tick();
    end
    bus.start = 1'b0;
    chk("done_pulse", {26'd0, outs()}, 32'h02);
    tick();
    chk("idle_after_done", {26'd0, outs()}, 32'h00);
  endtask
  task automatic bad_size(input int size);
    bus.data_size = SIZE_W'(size);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("err_pulse", {26'd0, outs()}, 32'h01);
    tick();
    chk("err_clear", {26'd0, outs()}, 32'h00);
  endtask
  initial begin
    bus.payload_0 = '0;
    bus.payload_1 = '0;
    bus.data_size = '0;
    bus.start = 1'b0;
    #2;
    chk("reset_state", {26'd0, outs()}, 32'h00);
    tick();
    hreset_n = 1'b1;
    tick();
    chk("post_reset_idle", {26'd0, outs()}, 32'h00);
    run_frame(8'hA5, 8'h00, 8, -1);
    run_frame(8'hFF, 8'h3C, 16, -1);
    bad_size(0);
    bad_size(17);
    bad_size(31);
    run_frame(8'h5A, 8'h00, 8, 9);
    run_frame(8'h07, 8'h00, 3, -1);
    run_frame(8'h01, 8'h80, 1, -1);
    // abort a frame in its tenth cycle
    bus.payload_0 = 8'hC3;
    bus.data_size = SIZE_W'(8);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    hreset_n = 1'b0;
    #1;
    chk("async_abort", {26'd0, outs()}, 32'h00);
    tick();
    chk("no_done_in_reset", {26'd0, outs()}, 32'h00);
    hreset_n = 1'b1;
    tick();
    chk("idle_after_abort", {26'd0, outs()}, 32'h00);
    run_frame(8'hC3, 8'h00, 8, -1);
    for (int k = 0; k < 20; k++) begin
      if ($urandom_range(0, 3) == 0) bad_size($urandom_range(0, 1) ? 0 : $urandom_range(17, 31));
      else run_frame(8'($urandom), 8'($urandom), $urandom_range(1, 16), $urandom_range(0, 1) ? int'($urandom_range(0, 30)) : -1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
